// File: rtl/sdram_pkg.sv
// Shared widths, FSM encoding and master indices for the SDRAM port arbiter.
package sdram_pkg;
  localparam int ADDR_W = 26;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_BUSY    = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  localparam int MASTER_DCACHE = 0;
  localparam int MASTER_ICACHE = 1;
  localparam int MASTER_VGA    = 2;
endpackage

// File: rtl/rr_priority_select.sv
// Round-robin pick: first set request at or after ptr_i, wrapping; purely combinational.
// Returns a one-hot grant, its index and whether any request was found.
module rr_priority_select #(
  parameter int NUM_MASTERS = 3,
  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic [NUM_MASTERS-1:0] req_i,
  input  logic [IDX_W-1:0]       ptr_i,
  output logic [NUM_MASTERS-1:0] gnt_o,
  output logic [IDX_W-1:0]       idx_o,
  output logic                   any_o
);
  logic [IDX_W:0] cand;

  // Walk the search order backwards so the last hit is the highest-priority one.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    for (int off = NUM_MASTERS - 1; off >= 0; off--) begin
      cand = {1'b0, ptr_i} + (IDX_W + 1)'(off);
      if (cand >= (IDX_W + 1)'(NUM_MASTERS)) begin
        cand = cand - (IDX_W + 1)'(NUM_MASTERS);
      end
      if (req_i[cand[IDX_W-1:0]]) begin
        gnt_o                   = '0;
        gnt_o[cand[IDX_W-1:0]]  = 1'b1;
        idx_o                   = cand[IDX_W-1:0];
        any_o                   = 1'b1;
      end
    end
  end
endmodule

// File: rtl/sdram_arbiter.sv
// Round-robin share of one SDRAM controller port; one cycle of arbitration, registered command,
// one RELEASE cycle after each complete. Masters wait by holding request; no request is dropped.
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter int NUM_MASTERS    = 3,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_MASTERS-1:0]        m_request,
  input  logic [NUM_MASTERS-1:0]        m_write,
  input  logic [ADDR_W*NUM_MASTERS-1:0] m_address,
  input  logic [NUM_MASTERS-1:0]        m_burst,
  input  logic [DATA_W*NUM_MASTERS-1:0] m_wdata,
  input  logic [BE_W*NUM_MASTERS-1:0]   m_byte_en,
  output logic [DATA_W-1:0]             m_rdata,
  output logic [NUM_MASTERS-1:0]        m_valid,
  output logic [NUM_MASTERS-1:0]        m_complete,
  output logic                          ctrl_request,
  output logic                          ctrl_write,
  output logic [ADDR_W-1:0]             ctrl_address,
  output logic                          ctrl_burst,
  output logic [DATA_W-1:0]             ctrl_wdata,
  output logic [BE_W-1:0]               ctrl_byte_en,
  input  logic [DATA_W-1:0]             ctrl_rdata,
  input  logic                          ctrl_valid,
  input  logic                          ctrl_complete,
  output logic [NUM_MASTERS-1:0]        grant,
  output logic                          timeout_error
);
  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  logic [1:0]             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]       gidx_q, gidx_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic                   req_q, req_d;
  logic                   write_q, write_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic                   burst_q, burst_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d;
  logic [BE_W-1:0]        be_q, be_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   err_q, err_d;

  logic [NUM_MASTERS-1:0] sel_gnt;
  logic [IDX_W-1:0]       sel_idx;
  logic                   sel_any;

  rr_priority_select #(.NUM_MASTERS(NUM_MASTERS)) u_select (
    .req_i (m_request),
    .ptr_i (ptr_q),
    .gnt_o (sel_gnt),
    .idx_o (sel_idx),
    .any_o (sel_any)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    ptr_d   = ptr_q;
    req_d   = req_q;
    write_d = write_q;
    addr_d  = addr_q;
    burst_d = burst_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (sel_any) begin
          grant_d = sel_gnt;
          gidx_d  = sel_idx;
          req_d   = 1'b1;
          write_d = m_write[sel_idx];
          addr_d  = m_address[int'(sel_idx)*ADDR_W +: ADDR_W];
          burst_d = m_burst[sel_idx];
          wdata_d = m_wdata[int'(sel_idx)*DATA_W +: DATA_W];
          be_d    = m_byte_en[int'(sel_idx)*BE_W +: BE_W];
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (ctrl_complete) begin
          req_d   = 1'b0;
          grant_d = '0;
          ptr_d   = (gidx_q == IDX_W'(NUM_MASTERS - 1)) ? '0 : gidx_q + 1'b1;
          cnt_d   = '0;
          state_d = ST_RELEASE;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Sticky: a late complete does not clear a timeout already flagged.
  assign err_d = err_q | (cnt_d == CNT_MAX);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      ptr_q   <= '0;
      req_q   <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      burst_q <= 1'b0;
      wdata_q <= '0;
      be_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
      req_q   <= req_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      burst_q <= burst_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign grant         = grant_q;
  assign ctrl_request  = req_q;
  assign ctrl_write    = write_q;
  assign ctrl_address  = addr_q;
  assign ctrl_burst    = burst_q;
  assign ctrl_wdata    = wdata_q;
  assign ctrl_byte_en  = be_q;
  assign timeout_error = err_q;
  assign m_rdata       = ctrl_rdata;
  assign m_valid       = grant_q & {NUM_MASTERS{ctrl_valid}};
  assign m_complete    = grant_q & {NUM_MASTERS{ctrl_complete}};
endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: table-driven single-master read plus hand-written
// reset, round-robin, write-hold, burst and timeout sequences.
module tb_sdram_arbiter;
  import sdram_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic [2:0]  m_request, m_write, m_burst;
  logic [77:0] m_address;
  logic [95:0] m_wdata;
  logic [11:0] m_byte_en;
  logic [31:0] m_rdata;
  logic [2:0]  m_valid, m_complete;
  logic        ctrl_request, ctrl_write, ctrl_burst;
  logic [25:0] ctrl_address;
  logic [31:0] ctrl_wdata, ctrl_rdata;
  logic [3:0]  ctrl_byte_en;
  logic        ctrl_valid, ctrl_complete;
  logic [2:0]  grant;
  logic        timeout_error;

  int n_cmp = 0;
  int n_bad = 0;

  sdram_arbiter #(.NUM_MASTERS(3), .TIMEOUT_CYCLES(16)) dut (
    .clock(clock), .reset(reset),
    .m_request(m_request), .m_write(m_write), .m_address(m_address), .m_burst(m_burst),
    .m_wdata(m_wdata), .m_byte_en(m_byte_en), .m_rdata(m_rdata), .m_valid(m_valid),
    .m_complete(m_complete), .ctrl_request(ctrl_request), .ctrl_write(ctrl_write),
    .ctrl_address(ctrl_address), .ctrl_burst(ctrl_burst), .ctrl_wdata(ctrl_wdata),
    .ctrl_byte_en(ctrl_byte_en), .ctrl_rdata(ctrl_rdata), .ctrl_valid(ctrl_valid),
    .ctrl_complete(ctrl_complete), .grant(grant), .timeout_error(timeout_error)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0] req;
    logic       cv;
    logic       cc;
    logic [2:0] e_grant;
    logic       e_creq;
    logic [2:0] e_valid;
    logic [2:0] e_comp;
  } vec_t;

  vec_t       tbl[8];
  logic [2:0] rr_exp[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b0;
    #1;
    chk({tag, " rst grant"}, grant, 0);
    chk({tag, " rst creq"}, ctrl_request, 0);
    chk({tag, " rst terr"}, timeout_error, 0);
    chk({tag, " rst addr"}, ctrl_address, 0);
    chk({tag, " rst wdata"}, ctrl_wdata, 0);
    for (int i = 0; i < 3; i++) begin
      step;
      chk({tag, " rst hold grant"}, grant, 0);
      chk({tag, " rst hold creq"}, ctrl_request, 0);
      chk({tag, " rst hold terr"}, timeout_error, 0);
    end
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int vcnt;
    int other;
    tbl[0] = '{3'b010, 1'b0, 1'b0, 3'b000, 1'b0, 3'b000, 3'b000};
    tbl[1] = '{3'b010, 1'b0, 1'b0, 3'b010, 1'b1, 3'b000, 3'b000};
    tbl[2] = '{3'b010, 1'b1, 1'b0, 3'b010, 1'b1, 3'b010, 3'b000};
    tbl[3] = '{3'b010, 1'b1, 1'b0, 3'b010, 1'b1, 3'b010, 3'b000};
    tbl[4] = '{3'b010, 1'b0, 1'b0, 3'b010, 1'b1, 3'b000, 3'b000};
    tbl[5] = '{3'b010, 1'b1, 1'b1, 3'b010, 1'b1, 3'b010, 3'b010};
    tbl[6] = '{3'b010, 1'b0, 1'b0, 3'b000, 1'b0, 3'b000, 3'b000};
    tbl[7] = '{3'b000, 1'b0, 1'b1, 3'b000, 1'b0, 3'b000, 3'b000};
    rr_exp[0] = 3'b001;
    rr_exp[1] = 3'b010;
    rr_exp[2] = 3'b100;
    rr_exp[3] = 3'b001;

    m_request = 3'b111; m_write = '0; m_burst = '0;
    m_address = '0; m_wdata = '0; m_byte_en = '0;
    ctrl_rdata = '0; ctrl_valid = 1'b0; ctrl_complete = 1'b0;

    // Reset with all masters requesting; first grant must go to the data cache.
    do_reset("init");
    step;
    chk("first grant", grant, 3'b001);
    chk("first creq", ctrl_request, 1);
    ctrl_complete = 1'b1;
    #1;
    chk("first complete", m_complete, 3'b001);
    step;
    ctrl_complete = 1'b0;
    m_request = 3'b000;
    #1;
    chk("first release creq", ctrl_request, 0);
    step;

    // Single icache read, pointer now at master 1.
    m_address[25:0]  = 26'h3000000;
    m_address[51:26] = 26'h0001234;
    m_address[77:52] = 26'h1111111;
    for (int i = 0; i < 8; i++) begin
      m_request = tbl[i].req;
      ctrl_valid = tbl[i].cv;
      ctrl_complete = tbl[i].cc;
      #1;
      chk($sformatf("row%0d grant", i), grant, tbl[i].e_grant);
      chk($sformatf("row%0d creq", i), ctrl_request, tbl[i].e_creq);
      chk($sformatf("row%0d valid", i), m_valid, tbl[i].e_valid);
      chk($sformatf("row%0d complete", i), m_complete, tbl[i].e_comp);
      step;
    end
    ctrl_valid = 1'b0;
    ctrl_complete = 1'b0;
    chk("read addr held", ctrl_address, 26'h0001234);
    chk("read write flag", ctrl_write, 0);
    ctrl_rdata = 32'hCAFEF00D;
    #1;
    chk("rdata broadcast", m_rdata, 32'hCAFEF00D);

    // Three continuous requesters rotate 0,1,2,0 with a grant-free gap between owners.
    m_request = 3'b111;
    do_reset("rr");
    step;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rr%0d grant", k), grant, rr_exp[k]);
      chk($sformatf("rr%0d creq", k), ctrl_request, 1);
      ctrl_complete = 1'b1;
      #1;
      chk($sformatf("rr%0d complete", k), m_complete, rr_exp[k]);
      step;
      ctrl_complete = 1'b0;
      #1;
      chk($sformatf("rr%0d release gap", k), grant, 0);
      step;
      chk($sformatf("rr%0d idle gap", k), grant, 0);
      step;
    end
    chk("rr next owner", grant, 3'b010);

    // Reset in the middle of a transaction.
    do_reset("midbusy");

    // Data cache write; command stays frozen while master inputs change.
    m_write[0] = 1'b1;
    m_address[25:0] = 26'h2ABCDEF;
    m_wdata[31:0] = 32'hDEADBEEF;
    m_byte_en[3:0] = 4'b0011;
    m_request = 3'b001;
    step;
    chk("wr grant", grant, 3'b001);
    chk("wr write", ctrl_write, 1);
    chk("wr addr", ctrl_address, 26'h2ABCDEF);
    chk("wr wdata", ctrl_wdata, 32'hDEADBEEF);
    chk("wr be", ctrl_byte_en, 4'b0011);
    m_wdata[31:0] = 32'h12345678;
    m_byte_en[3:0] = 4'b1111;
    m_write[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step;
      chk($sformatf("wr hold wdata %0d", i), ctrl_wdata, 32'hDEADBEEF);
      chk($sformatf("wr hold be %0d", i), ctrl_byte_en, 4'b0011);
    end
    ctrl_complete = 1'b1;
    step;
    ctrl_complete = 1'b0;
    m_request = 3'b000;
    #1;
    chk("wr release creq", ctrl_request, 0);
    chk("wr idle wdata", ctrl_wdata, 32'hDEADBEEF);
    step;

    // VGA burst: 8 data beats then complete; request dropped early is still served.
    m_burst = 3'b100;
    m_request = 3'b100;
    step;
    chk("vga grant", grant, 3'b100);
    chk("vga burst", ctrl_burst, 1);
    chk("vga addr", ctrl_address, 26'h1111111);
    vcnt = 0;
    other = 0;
    for (int i = 0; i < 8; i++) begin
      ctrl_valid = 1'b1;
      if (i == 4) m_request = 3'b000;
      #1;
      if (m_valid[2]) vcnt++;
      if (|m_valid[1:0]) other++;
      step;
    end
    ctrl_valid = 1'b0;
    ctrl_complete = 1'b1;
    #1;
    chk("vga complete", m_complete, 3'b100);
    chk("vga valid count", vcnt, 8);
    chk("vga stray valid", other, 0);
    step;
    ctrl_complete = 1'b0;
    #1;
    chk("vga release grant", grant, 0);
    step;

    // Controller never completes: timeout after 16 BUSY cycles, sticky.
    m_burst = 3'b000;
    m_request = 3'b001;
    step;
    chk("to grant", grant, 3'b001);
    for (int i = 1; i <= 20; i++) begin
      step;
      chk($sformatf("timeout cyc%0d", i), timeout_error, (i >= 16) ? 1 : 0);
    end
    chk("to still busy", ctrl_request, 1);
    m_request = 3'b000;
    do_reset("timeout");
    step;
    chk("to cleared", timeout_error, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
